// File: rtl/bus_arbiter.sv
// Two-master (instruction/data) round-robin arbiter with a five-region address decoder.
// Define ARBITER_TIMEOUT_EN to bound how long the selected slave may stall a transaction.
module bus_arbiter #(
    parameter logic [31:0] IRAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] IRAM_TOP   = 32'h0000_1000,
    parameter logic [31:0] DRAM_BASE  = 32'h0002_0000,
    parameter logic [31:0] DRAM_TOP   = 32'h0002_1000,
    parameter logic [31:0] UART_BASE  = 32'h0010_0000,
    parameter logic [31:0] UART_TOP   = 32'h0010_0004,
    parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
    parameter logic [31:0] CLINT_TOP  = 32'h0200_C000,
    parameter logic [31:0] PLIC_BASE  = 32'h0C00_0000,
    parameter logic [31:0] PLIC_TOP   = 32'h1000_0000,
    parameter int          TIMEOUT    = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic        imem_ready,
    output logic [31:0] imem_rdata,
    output logic        imem_error,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_ready,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,
    output logic        slv_valid,
    output logic [4:0]  slv_sel,
    output logic [31:0] slv_addr,
    output logic [31:0] slv_wdata,
    output logic [3:0]  slv_wstrb,
    input  logic        slv_ready,
    input  logic [31:0] slv_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    // Index order matches the slv_sel bit order {plic, clint, uart, dram, iram}.
    localparam logic [4:0][31:0] REGION_BASE = {PLIC_BASE, CLINT_BASE, UART_BASE, DRAM_BASE, IRAM_BASE};
    localparam logic [4:0][31:0] REGION_TOP  = {PLIC_TOP,  CLINT_TOP,  UART_TOP,  DRAM_TOP,  IRAM_TOP};

    state_t      state_reg;
    logic        last_grant_reg;  // 1 = data port; also names the owner while BUSY/ERR
    logic        pick;
    logic [31:0] req_addr;
    logic [4:0]  hit;
    logic        complete;
    logic        fault;
    logic        done;
    logic        expired;

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        if (imem_valid && dmem_valid) begin
            pick = ~last_grant_reg;
        end else begin
            pick = dmem_valid;
        end
    end

    assign req_addr = pick ? dmem_addr : imem_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_decode
            logic above_base;
            if (REGION_BASE[gi] == 32'h0) begin : g_zero_base
                assign above_base = 1'b1;
            end else begin : g_base
                assign above_base = (req_addr >= REGION_BASE[gi]);
            end
            assign hit[gi] = above_base && (req_addr < REGION_TOP[gi]);
        end
    endgenerate

`ifdef ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    // A slave answering in the very cycle the limit is reached still completes normally.
    assign expired = (state_reg == BUSY) && !slv_ready && (count_reg == CW'(TIMEOUT));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign expired        = 1'b0;
`endif

    assign complete = (state_reg == BUSY) && slv_ready;
    assign fault    = (state_reg == ERR) || expired;
    assign done     = complete || fault;

    assign imem_ready = done && !last_grant_reg;
    assign dmem_ready = done &&  last_grant_reg;
    assign imem_error = fault && !last_grant_reg;
    assign dmem_error = fault &&  last_grant_reg;
    assign imem_rdata = (complete && !last_grant_reg) ? slv_rdata : 32'h0;
    assign dmem_rdata = (complete &&  last_grant_reg) ? slv_rdata : 32'h0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            slv_valid      <= 1'b0;
            slv_sel        <= 5'h0;
            slv_addr       <= 32'h0;
            slv_wdata      <= 32'h0;
            slv_wstrb      <= 4'h0;
`ifdef ARBITER_TIMEOUT_EN
            count_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (imem_valid || dmem_valid) begin
                        last_grant_reg <= pick;
                        slv_addr       <= req_addr;
                        // The instruction port is read-only.
                        slv_wdata      <= pick ? dmem_wdata : 32'h0;
                        slv_wstrb      <= pick ? dmem_wstrb : 4'h0;
                        slv_sel        <= hit;
                        slv_valid      <= |hit;
                        state_reg      <= (|hit) ? BUSY : ERR;
`ifdef ARBITER_TIMEOUT_EN
                        count_reg      <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (complete || expired) begin
                        state_reg <= IDLE;
                        slv_valid <= 1'b0;
                        slv_sel   <= 5'h0;
                    end
`ifdef ARBITER_TIMEOUT_EN
                    else begin
                        count_reg <= count_reg + CW'(1);
                    end
`endif
                end
                ERR: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    slv_valid <= 1'b0;
                    slv_sel   <= 5'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_bus_arbiter;

`ifdef ARBITER_TIMEOUT_EN
    localparam int TOUT = 8;
`else
    localparam int TOUT = 1024;
`endif

    localparam logic [31:0] BASE_TAB [5] = '{32'h0, 32'h20000, 32'h100000, 32'h2000000, 32'h0C000000};
    localparam logic [31:0] TOP_TAB  [5] = '{32'h1000, 32'h21000, 32'h100004, 32'h200C000, 32'h10000000};
    localparam logic [31:0] POOL [16] = '{
        32'h0, 32'h10, 32'hFFC, 32'h1000, 32'h20000, 32'h20FFC, 32'h21000, 32'h100000,
        32'h100004, 32'h2000000, 32'h200BFF8, 32'h200C000, 32'h0C000000, 32'h0FFFFFFC,
        32'h10000000, 32'hFFFFFFFC};

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr = 32'h0;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_error;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = 32'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic [3:0]  dmem_wstrb = 4'h0;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_error;
    logic        slv_valid;
    logic [4:0]  slv_sel;
    logic [31:0] slv_addr;
    logic [31:0] slv_wdata;
    logic [3:0]  slv_wstrb;
    logic        slv_ready = 1'b0;
    logic [31:0] slv_rdata = 32'h0;

    always #5 clock = ~clock;

    bus_arbiter #(.TIMEOUT(TOUT)) dut (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .imem_error(imem_error),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .dmem_error(dmem_error),
        .slv_valid(slv_valid), .slv_sel(slv_sel), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_wstrb(slv_wstrb), .slv_ready(slv_ready), .slv_rdata(slv_rdata)
    );

    int checks = 0;
    int failures = 0;

    // Transaction-level model: at most one outstanding transaction.
    bit          cur_act = 1'b0;
    int          cur_m = 0;        // 0 = instruction port, 1 = data port
    logic [31:0] cur_addr = 32'h0;
    logic [31:0] cur_wdata = 32'h0;
    logic [3:0]  cur_wstrb = 4'h0;
    int          cur_reg = -1;
    int          cur_wait = 0;
    int          last_m = 1;
    bit          i_done = 1'b0;
    bit          d_done = 1'b0;
    int          sw = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        for (int i = 0; i < 5; i++) begin
            if (a >= BASE_TAB[i] && a < TOP_TAB[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return POOL[r];
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    // Compare this cycle's DUT outputs with the model, then advance the model one cycle.
    task automatic mc();
        bit          ev, er, ee;
        logic [4:0]  esel;
        logic [31:0] erd;
        @(negedge clock);
        ev = 1'b0; er = 1'b0; ee = 1'b0; esel = 5'h0; erd = 32'h0;
        if (!reset) begin
            cur_act = 1'b0;
            last_m  = 1;
        end
        if (cur_act) begin
            if (cur_reg < 0) begin
                er = 1'b1;
                ee = 1'b1;
            end else begin
                ev   = 1'b1;
                esel = 5'(1 << cur_reg);
                if (slv_ready) begin
                    er  = 1'b1;
                    erd = slv_rdata;
                end
`ifdef ARBITER_TIMEOUT_EN
                else if (cur_wait == TOUT) begin
                    er = 1'b1;
                    ee = 1'b1;
                end
`endif
            end
        end
        chk1("slv_valid", slv_valid, ev);
        chk32("slv_sel", {27'h0, slv_sel}, {27'h0, esel});
        if (ev) begin
            chk32("slv_addr", slv_addr, cur_addr);
            chk32("slv_wdata", slv_wdata, cur_wdata);
            chk32("slv_wstrb", {28'h0, slv_wstrb}, {28'h0, cur_wstrb});
        end
        chk1("imem_ready", imem_ready, er && cur_m == 0);
        chk1("imem_error", imem_error, ee && cur_m == 0);
        chk32("imem_rdata", imem_rdata, (er && cur_m == 0) ? erd : 32'h0);
        chk1("dmem_ready", dmem_ready, er && cur_m == 1);
        chk1("dmem_error", dmem_error, ee && cur_m == 1);
        chk32("dmem_rdata", dmem_rdata, (er && cur_m == 1) ? erd : 32'h0);
        i_done = er && cur_m == 0;
        d_done = er && cur_m == 1;
        if (!reset) begin
            cur_act = 1'b0;
        end else if (cur_act) begin
            if (er) cur_act = 1'b0;
            else cur_wait++;
        end else if (imem_valid || dmem_valid) begin
            cur_m     = (imem_valid && dmem_valid) ? 1 - last_m : (imem_valid ? 0 : 1);
            last_m    = cur_m;
            cur_act   = 1'b1;
            cur_addr  = (cur_m == 1) ? dmem_addr : imem_addr;
            cur_wdata = (cur_m == 1) ? dmem_wdata : 32'h0;
            cur_wstrb = (cur_m == 1) ? dmem_wstrb : 4'h0;
            cur_reg   = region_of(cur_addr);
            cur_wait  = 0;
        end
    endtask

    task automatic drive_random();
        if (!reset) reset = 1'b1;
        else if ($urandom_range(0, 299) == 0) reset = 1'b0;
        if (i_done || !imem_valid) begin
            if ($urandom_range(0, 1) == 1) begin
                imem_valid = 1'b1;
                imem_addr  = pick_addr();
            end else begin
                imem_valid = 1'b0;
            end
        end
        if (d_done || !dmem_valid) begin
            if ($urandom_range(0, 1) == 1) begin
                dmem_valid = 1'b1;
                dmem_addr  = pick_addr();
                dmem_wdata = $urandom;
                dmem_wstrb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            end else begin
                dmem_valid = 1'b0;
            end
        end
        if (slv_valid) begin
            slv_ready = (sw >= 3) || ($urandom_range(0, 2) == 0);
            sw = slv_ready ? 0 : sw + 1;
        end else begin
            slv_ready = ($urandom_range(0, 4) == 0);
            sw = 0;
        end
        slv_rdata = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        // Reset values, with both masters already requesting.
        imem_valid = 1'b1; imem_addr = 32'h100;
        dmem_valid = 1'b1; dmem_addr = 32'h20000; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
        slv_ready = 1'b1; slv_rdata = 32'h5555_0000;
        adv();
        mc();
        chk1("rst_slv_valid", slv_valid, 1'b0);
        chk32("rst_slv_sel", {27'h0, slv_sel}, 32'h0);
        chk32("rst_slv_addr", slv_addr, 32'h0);
        chk32("rst_slv_wdata", slv_wdata, 32'h0);
        chk32("rst_slv_wstrb", {28'h0, slv_wstrb}, 32'h0);
        chk1("rst_imem_ready", imem_ready, 1'b0);
        chk1("rst_dmem_ready", dmem_ready, 1'b0);
        adv();
        reset = 1'b1;

        // Tie after reset: I, D, I, D over four back-to-back pairs with a zero-wait slave.
        for (int k = 0; k < 16; k++) begin
            mc();
            if (k % 2 == 1) begin
                chk1("tie_imem_ready", imem_ready, ((k / 2) % 2) == 0);
                chk1("tie_dmem_ready", dmem_ready, ((k / 2) % 2) == 1);
            end else begin
                chk1("tie_idle_ready", imem_ready || dmem_ready, 1'b0);
            end
            adv();
            if (i_done) imem_addr = imem_addr + 32'h4;
            if (d_done) dmem_addr = dmem_addr + 32'h4;
        end
        imem_valid = 1'b0; dmem_valid = 1'b0; slv_ready = 1'b0;

        // Instruction read with two wait cycles.
        imem_valid = 1'b1; imem_addr = 32'h10;
        mc(); chk1("ird_req_ready", imem_ready, 1'b0); adv();
        for (int w = 0; w < 2; w++) begin
            mc();
            chk1("ird_slv_valid", slv_valid, 1'b1);
            chk32("ird_slv_sel", {27'h0, slv_sel}, 32'h1);
            chk32("ird_slv_wstrb", {28'h0, slv_wstrb}, 32'h0);
            chk32("ird_slv_addr", slv_addr, 32'h10);
            chk1("ird_wait_ready", imem_ready, 1'b0);
            adv();
        end
        slv_ready = 1'b1; slv_rdata = 32'hDEADBEEF;
        mc();
        chk1("ird_ready", imem_ready, 1'b1);
        chk32("ird_rdata", imem_rdata, 32'hDEADBEEF);
        chk1("ird_error", imem_error, 1'b0);
        adv();
        imem_valid = 1'b0; slv_ready = 1'b0;
        mc(); chk1("ird_one_pulse", imem_ready, 1'b0); chk1("ird_slv_drop", slv_valid, 1'b0); adv();

        // UART write held stable over three wait cycles.
        dmem_valid = 1'b1; dmem_addr = 32'h100000; dmem_wdata = 32'h41; dmem_wstrb = 4'hF;
        mc(); adv();
        for (int w = 0; w < 3; w++) begin
            mc();
            chk32("uwr_slv_sel", {27'h0, slv_sel}, 32'h4);
            chk32("uwr_slv_addr", slv_addr, 32'h100000);
            chk32("uwr_slv_wdata", slv_wdata, 32'h41);
            chk32("uwr_slv_wstrb", {28'h0, slv_wstrb}, 32'hF);
            chk1("uwr_wait_ready", dmem_ready, 1'b0);
            adv();
        end
        slv_ready = 1'b1;
        mc(); chk1("uwr_ready", dmem_ready, 1'b1); chk1("uwr_error", dmem_error, 1'b0); adv();
        dmem_valid = 1'b0; slv_ready = 1'b0;
        mc(); adv();

        // Read at DRAM top: unmapped, local error one cycle after the request.
        dmem_valid = 1'b1; dmem_addr = 32'h21000; dmem_wstrb = 4'h0; slv_rdata = 32'hA5A5_A5A5;
        mc(); adv();
        slv_ready = 1'b1;
        mc();
        chk1("unm_slv_valid", slv_valid, 1'b0);
        chk1("unm_ready", dmem_ready, 1'b1);
        chk1("unm_error", dmem_error, 1'b1);
        chk32("unm_rdata", dmem_rdata, 32'h0);
        adv();
        dmem_valid = 1'b0; slv_ready = 1'b0;
        mc(); chk1("unm_one_pulse", dmem_ready, 1'b0); adv();

        // Reset while BUSY on CLINT, then the same access completes normally.
        dmem_valid = 1'b1; dmem_addr = 32'h200BFF8;
        mc(); adv();
        mc(); chk32("clint_sel", {27'h0, slv_sel}, 32'h8);
        reset = 1'b0;
        #1;
        chk1("arst_slv_valid", slv_valid, 1'b0);
        chk32("arst_slv_sel", {27'h0, slv_sel}, 32'h0);
        chk32("arst_slv_addr", slv_addr, 32'h0);
        chk1("arst_ready", dmem_ready, 1'b0);
        adv();
        dmem_valid = 1'b0;
        mc(); chk1("arst_no_ready", dmem_ready, 1'b0); adv();
        reset = 1'b1; dmem_valid = 1'b1; slv_ready = 1'b1; slv_rdata = 32'h1234_5678;
        mc(); adv();
        mc();
        chk1("clint_ready", dmem_ready, 1'b1);
        chk32("clint_rdata", dmem_rdata, 32'h1234_5678);
        adv();
        dmem_valid = 1'b0; slv_ready = 1'b0;
        mc(); adv();

`ifdef ARBITER_TIMEOUT_EN
        // PLIC read never acknowledged: error once the count reaches TIMEOUT.
        dmem_valid = 1'b1; dmem_addr = 32'h0C000000;
        cyc = -1;
        for (int k = 0; k < 30 && cyc < 0; k++) begin
            mc();
            if (dmem_ready) begin
                cyc = k;
                chk1("tmo_error", dmem_error, 1'b1);
                chk32("tmo_rdata", dmem_rdata, 32'h0);
            end
            adv();
        end
        chk32("tmo_cycles", 32'(cyc), 32'd9);
        dmem_valid = 1'b0; slv_ready = 1'b1;
        mc(); chk1("tmo_late_ready", dmem_ready, 1'b0); chk1("tmo_slv_valid", slv_valid, 1'b0); adv();
        slv_ready = 1'b0;
`else
        cyc = 0;
`endif

        // Randomized traffic against the model.
        imem_valid = 1'b0; dmem_valid = 1'b0;
        for (int n = 0; n < 4000 + cyc; n++) begin
            drive_random();
            mc();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
